nx_instr_store: RTL and testbench
=================================

Name: nx_instr_store

Overview:
Per-node instruction memory that sits directly upstream of nx_node_core's instruction fetch port. It accepts instructions streamed in by the node's message/load path, writes them sequentially into a single-port RAM, and reports the populated count. It serves the core's fetch requests with 1-cycle read latency and asserts stall only when a buffered store must claim the RAM.

Parameters:
MAX_INSTRS, 512, instruction capacity (power of two)
INSTR_WIDTH, 36, bits per instruction word
STORE_DEPTH, 2, entries in the store holding FIFO (power of two, >=2)

Ports:
clk_i  input  1  clock
rstn_i  input  1  reset; asynchronous, active-low
clear_i  input  1  synchronous flush: populated count, overflow flag and store FIFO
store_data_i  input  INSTR_WIDTH  instruction to append
store_valid_i  input  1  store request
store_ready_o  output  1  store FIFO not full; transfer when valid & ready
populated_o  output  $clog2(MAX_INSTRS)+1  instructions written into RAM
overflow_o  output  1  sticky; a store was dropped because RAM was full
fetch_addr_i  input  $clog2(MAX_INSTRS)  fetch address from core
fetch_rd_i  input  1  fetch request
fetch_data_o  output  INSTR_WIDTH  fetched instruction
fetch_stall_o  output  1  fetch not accepted this cycle; requester holds addr/rd

Behaviour:
- Reset (rstn_i low, async): populated_o=0, overflow_o=0, store FIFO empty, store_ready_o=1, fetch_data_o=0, fetch_stall_o=0, write pointer 0. RAM contents are not reset.
- Store path: a word is pushed into the FIFO when store_valid_i & store_ready_o. store_ready_o = !fifo_full (registered flags).
- RAM arbitration, one access per cycle:
  - Store is granted if the FIFO is full, or if the FIFO is non-empty and fetch_rd_i=0.
  - Otherwise a pending fetch_rd_i is granted.
- fetch_stall_o = fetch_rd_i & store_grant. This is combinational from the registered FIFO-full flag and fetch_rd_i.
- Fetch latency: a request granted in cycle N drives fetch_data_o with RAM[fetch_addr_i] in N+1. fetch_data_o holds its value in cycles with no granted fetch.
- Store grant behaviour:
  - Pops the FIFO head and writes it to RAM[wr_ptr] if populated_o < MAX_INSTRS; wr_ptr and populated_o then increment.
  - If populated_o == MAX_INSTRS, the word is popped and discarded, overflow_o is set, and populated_o does not wrap.
- Simultaneous push and pop on a full FIFO: allowed. The pop frees space this cycle, but store_ready_o reflects only the registered full flag, so no push is accepted while full.
- Address and store to the same location in adjacent cycles: a fetch returns the RAM contents as of its grant cycle (read-before-write is impossible, since there is one access per cycle).
- fetch_addr_i >= populated_o is not checked; the RAM contents are returned.
- clear_i (synchronous, highest priority over store/fetch grant):
  - Empties the FIFO and zeroes wr_ptr, populated_o and overflow_o.
  - A fetch in the same cycle is stalled (fetch_stall_o=1).
  - A store push in the same cycle is dropped.
- rstn_i asserted mid-operation aborts any in-flight fetch; no fetch_data_o update occurs after reset release until a new grant.

Decomposition:
- Shared package nx_common_pkg holds:
  - typedef instr_t (logic [INSTR_WIDTH-1:0])
  - constants for address width ($clog2(MAX_INSTRS)) and count width (+1)
- Sub-module nx_fifo (parameterised width/depth, push/pop, full/empty, async active-low reset, sync flush) implements the store holding FIFO.
- The RAM is inferred inline as a single-port synchronous array.

Test Plan:
- Reset then push 3 words 0xA, 0xB, 0xC with fetch_rd_i=0 -> populated_o reaches 3 within 4 cycles; fetches of addresses 0, 1, 2 return 0xA, 0xB, 0xC one cycle after each request; fetch_stall_o stays 0.
- Continuous fetch_rd_i=1 while pushing 4 words back-to-back -> store_ready_o drops once the FIFO is full; fetch_stall_o pulses 1 cycle per drained word; all 4 words land at addresses 0..3 and populated_o=4.
- With MAX_INSTRS=8, push 10 words -> populated_o saturates at 8, overflow_o=1 after the 9th word, and RAM[0..7] is unchanged by words 9 and 10.
- Assert clear_i with 2 words in the FIFO and populated_o=5 -> next cycle populated_o=0, overflow_o=0, store_ready_o=1; the next pushed word lands at address 0.
- Drop rstn_i asynchronously mid-stream (FIFO holding 1 word, fetch in flight) -> all outputs are at reset values immediately; after release, the first push writes address 0.

Source files
------------

// File: rtl/nx_common_pkg.sv
// Shared types and sizing helpers for the nx node blocks.
package nx_common_pkg;

    localparam int MAX_INSTRS_DEF  = 512;
    localparam int INSTR_WIDTH_DEF = 36;
    localparam int ADDR_W          = $clog2(MAX_INSTRS_DEF);
    localparam int CNT_W           = ADDR_W + 1;

    typedef logic [INSTR_WIDTH_DEF-1:0] instr_t;

    // Owner of the single RAM port in a given cycle.
    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_STORE,
        GNT_FETCH,
        GNT_CLEAR
    } ram_gnt_e;

    // Address width for a table of n entries; never narrower than one bit.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nx_fifo.sv
// Small synchronous FIFO with registered full/empty flags and a sync flush.
module nx_fifo
    import nx_common_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = addr_width(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok, pop_ok;

    assign push_ok = push_i & ~full_q & ~flush_i;
    assign pop_ok  = pop_i & ~empty_q & ~flush_i;

    // Next pointers, occupancy and flags; flush wins over push/pop.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Control state register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        // NOTE: state flops use non-blocking assignment so all flops update together.
        if (!rstn_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage write; contents are qualified by the flags, so they carry no reset.
    always_ff @(posedge clk_i) begin
        // NOTE: data arrays are left unreset; resetting them costs a reset net per bit for nothing.
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/nx_instr_store.sv
// Per-node instruction store: buffers streamed-in instructions, appends them
// to a single-port RAM and serves core fetches with one cycle of latency.
module nx_instr_store
    import nx_common_pkg::*;
#(
    parameter int MAX_INSTRS  = 512,
    parameter int INSTR_WIDTH = 36,
    parameter int STORE_DEPTH = 2
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          clear_i,
    input  logic [INSTR_WIDTH-1:0]        store_data_i,
    input  logic                          store_valid_i,
    output logic                          store_ready_o,
    output logic [$clog2(MAX_INSTRS):0]   populated_o,
    output logic                          overflow_o,
    input  logic [$clog2(MAX_INSTRS)-1:0] fetch_addr_i,
    input  logic                          fetch_rd_i,
    output logic [INSTR_WIDTH-1:0]        fetch_data_o,
    output logic                          fetch_stall_o
);

    localparam int AW = addr_width(MAX_INSTRS);
    localparam int CW = AW + 1;

    logic                   fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [INSTR_WIDTH-1:0] fifo_head;
    ram_gnt_e               gnt;
    logic                   at_cap, ram_we;

    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]          populated_q, populated_d;
    logic                   overflow_q, overflow_d;
    logic [INSTR_WIDTH-1:0] fetch_data_q, fetch_data_d;
    logic [INSTR_WIDTH-1:0] mem_q [MAX_INSTRS];

    // Pushes during a flush are dropped; ready only follows the registered full flag.
    assign fifo_push     = store_valid_i & ~fifo_full & ~clear_i;
    assign fifo_pop      = (gnt == GNT_STORE);
    assign store_ready_o = ~fifo_full;

    nx_fifo #(
        .WIDTH (INSTR_WIDTH),
        .DEPTH (STORE_DEPTH)
    ) u_store_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .flush_i (clear_i),
        .push_i  (fifo_push),
        .data_i  (store_data_i),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // RAM port arbitration: clear, then a full or idle-port store, then fetch.
    always_comb begin
        gnt = GNT_NONE;
        if (clear_i)                                    gnt = GNT_CLEAR;
        else if (fifo_full || (!fifo_empty && !fetch_rd_i)) gnt = GNT_STORE;
        else if (fetch_rd_i)                            gnt = GNT_FETCH;
    end

    // Any cycle the core asks but does not own the port is a stall.
    assign fetch_stall_o = fetch_rd_i & ((gnt == GNT_STORE) | (gnt == GNT_CLEAR));

    assign at_cap = (populated_q == CW'(MAX_INSTRS));
    assign ram_we = (gnt == GNT_STORE) & ~at_cap;

    // Next write pointer, population count, overflow flag and fetch data.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        populated_d  = populated_q;
        overflow_d   = overflow_q;
        fetch_data_d = fetch_data_q;
        unique case (gnt)
            GNT_CLEAR: begin
                wr_ptr_d    = '0;
                populated_d = '0;
                overflow_d  = 1'b0;
            end
            GNT_STORE: begin
                if (at_cap) begin
                    overflow_d = 1'b1;
                end else begin
                    wr_ptr_d    = wr_ptr_q + AW'(1);
                    populated_d = populated_q + CW'(1);
                end
            end
            GNT_FETCH: fetch_data_d = mem_q[fetch_addr_i];
            default: ;
        endcase
    end

    // Control and fetch-data registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q     <= '0;
            populated_q  <= '0;
            overflow_q   <= 1'b0;
            fetch_data_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            populated_q  <= populated_d;
            overflow_q   <= overflow_d;
            fetch_data_q <= fetch_data_d;
        end
    end

    // Instruction RAM write port.
    always_ff @(posedge clk_i) begin
        if (ram_we) mem_q[wr_ptr_q] <= fifo_head;
    end

    assign populated_o  = populated_q;
    assign overflow_o   = overflow_q;
    assign fetch_data_o = fetch_data_q;

endmodule

// File: tb/tb_nx_instr_store.sv
// Self-checking bench for nx_instr_store: directed scenarios plus a random
// phase, compared every cycle against a queue/array model of the store.
module tb_nx_instr_store;

    localparam int MAX = 8;
    localparam int W   = 36;
    localparam int D   = 2;

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b1;
    logic          clear_i = 1'b0;
    logic [W-1:0]  store_data_i = '0;
    logic          store_valid_i = 1'b0;
    logic          store_ready_o;
    logic [3:0]    populated_o;
    logic          overflow_o;
    logic [2:0]    fetch_addr_i = '0;
    logic          fetch_rd_i = 1'b0;
    logic [W-1:0]  fetch_data_o;
    logic          fetch_stall_o;

    int n_checks = 0;
    int n_fail   = 0;
    int stall_seen = 0;
    int ready_low  = 0;

    nx_instr_store #(
        .MAX_INSTRS  (MAX),
        .INSTR_WIDTH (W),
        .STORE_DEPTH (D)
    ) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .clear_i       (clear_i),
        .store_data_i  (store_data_i),
        .store_valid_i (store_valid_i),
        .store_ready_o (store_ready_o),
        .populated_o   (populated_o),
        .overflow_o    (overflow_o),
        .fetch_addr_i  (fetch_addr_i),
        .fetch_rd_i    (fetch_rd_i),
        .fetch_data_o  (fetch_data_o),
        .fetch_stall_o (fetch_stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_ram [MAX];
    bit           m_wr [MAX];
    int           m_pop   = 0;
    bit           m_ovf   = 0;
    logic [W-1:0] m_fdata = '0;
    bit           m_fknown = 1;
    bit           mdl_full, mdl_sg, mdl_push;
    logic [W-1:0] mdl_w;

    initial for (int i = 0; i < MAX; i++) m_wr[i] = 0;

    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            m_q.delete();
            m_pop    = 0;
            m_ovf    = 0;
            m_fdata  = '0;
            m_fknown = 1;
        end else if (clear_i) begin
            m_q.delete();
            m_pop = 0;
            m_ovf = 0;
        end else begin
            mdl_full = (m_q.size() == D);
            mdl_sg   = mdl_full || (m_q.size() != 0 && !fetch_rd_i);
            mdl_push = store_valid_i && !mdl_full;
            if (mdl_sg) begin
                mdl_w = m_q.pop_front();
                if (m_pop < MAX) begin
                    m_ram[m_pop] = mdl_w;
                    m_wr[m_pop]  = 1;
                    m_pop++;
                end else begin
                    m_ovf = 1;
                end
            end else if (fetch_rd_i) begin
                m_fdata  = m_ram[fetch_addr_i];
                m_fknown = m_wr[fetch_addr_i];
            end
            if (mdl_push) m_q.push_back(store_data_i);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk_i) begin
        bit e_full, e_sg;
        e_full = (m_q.size() == D);
        e_sg   = !clear_i && (e_full || (m_q.size() != 0 && !fetch_rd_i));
        check("store_ready", 64'(store_ready_o), 64'(!e_full));
        check("populated",   64'(populated_o),   64'(m_pop));
        check("overflow",    64'(overflow_o),    64'(m_ovf));
        check("fetch_stall", 64'(fetch_stall_o), 64'(fetch_rd_i && (clear_i || e_sg)));
        if (m_fknown) check("fetch_data", 64'(fetch_data_o), 64'(m_fdata));
        if (fetch_stall_o)  stall_seen++;
        if (!store_ready_o) ready_low++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] d);
        int n;
        store_valid_i = 1'b1;
        store_data_i  = d;
        n = 0;
        while (!store_ready_o && n < 20) begin
            cyc();
            n++;
        end
        if (n == 20) check("push_timeout", 64'(1), 64'(0));
        cyc();
        store_valid_i = 1'b0;
    endtask

    task automatic fetch_check(input logic [2:0] a, input logic [W-1:0] exp, input string name);
        fetch_rd_i   = 1'b1;
        fetch_addr_i = a;
        cyc();
        check(name, 64'(fetch_data_o), 64'(exp));
        fetch_rd_i = 1'b0;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, r0;
        #1 rstn_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_ready",     64'(store_ready_o), 64'(1));
        check("rst_populated", 64'(populated_o),   64'(0));
        check("rst_overflow",  64'(overflow_o),    64'(0));
        check("rst_fdata",     64'(fetch_data_o),  64'(0));
        check("rst_stall",     64'(fetch_stall_o), 64'(0));
        rstn_i = 1'b1;
        cyc();

        // Three stores with the core idle, then fetch them back.
        s0 = stall_seen;
        push_word(36'hA);
        push_word(36'hB);
        push_word(36'hC);
        cyc();
        check("t1_populated", 64'(populated_o), 64'(3));
        fetch_check(3'd0, 36'hA, "t1_fetch0");
        fetch_check(3'd1, 36'hB, "t1_fetch1");
        fetch_check(3'd2, 36'hC, "t1_fetch2");
        check("t1_no_stall", 64'(stall_seen - s0), 64'(0));

        // Back-to-back stores against a continuously fetching core.
        do_clear();
        fetch_rd_i   = 1'b1;
        fetch_addr_i = 3'd0;
        s0 = stall_seen;
        r0 = ready_low;
        for (int i = 0; i < 4; i++) push_word(36'h100 + 36'(i));
        repeat (3) cyc();
        check("t2_stalls",    64'(stall_seen - s0), 64'(3));
        check("t2_ready_low", 64'(ready_low - r0),  64'(3));
        fetch_rd_i = 1'b0;
        repeat (3) cyc();
        check("t2_populated", 64'(populated_o), 64'(4));
        for (int i = 0; i < 4; i++) fetch_check(3'(i), 36'h100 + 36'(i), "t2_fetch");

        // Fill past capacity.
        do_clear();
        for (int i = 0; i < 8; i++) push_word(36'h300 + 36'(i));
        repeat (3) cyc();
        check("t3_populated8", 64'(populated_o), 64'(8));
        check("t3_no_ovf",     64'(overflow_o),  64'(0));
        push_word(36'h308);
        repeat (3) cyc();
        check("t3_ovf9",       64'(overflow_o),  64'(1));
        push_word(36'h309);
        repeat (3) cyc();
        check("t3_saturated",  64'(populated_o), 64'(8));
        for (int i = 0; i < 8; i++) fetch_check(3'(i), 36'h300 + 36'(i), "t3_fetch");

        // Clear with two words buffered and five in RAM.
        do_clear();
        for (int i = 0; i < 5; i++) push_word(36'h400 + 36'(i));
        repeat (3) cyc();
        check("t4_populated5", 64'(populated_o), 64'(5));
        fetch_rd_i   = 1'b1;
        fetch_addr_i = 3'd0;
        push_word(36'h410);
        push_word(36'h411);
        check("t4_fifo_full", 64'(store_ready_o), 64'(0));
        clear_i       = 1'b1;
        store_valid_i = 1'b1;
        store_data_i  = 36'h999;
        #1;
        check("t4_clear_stall", 64'(fetch_stall_o), 64'(1));
        cyc();
        clear_i       = 1'b0;
        store_valid_i = 1'b0;
        fetch_rd_i    = 1'b0;
        check("t4_populated0", 64'(populated_o),   64'(0));
        check("t4_ovf0",       64'(overflow_o),    64'(0));
        check("t4_ready",      64'(store_ready_o), 64'(1));
        push_word(36'h555);
        repeat (3) cyc();
        check("t4_populated1", 64'(populated_o), 64'(1));
        fetch_check(3'd0, 36'h555, "t4_fetch0");

        // Asynchronous reset with a buffered word and a fetch outstanding.
        fetch_rd_i   = 1'b1;
        fetch_addr_i = 3'd1;
        push_word(36'h666);
        #2 rstn_i = 1'b0;
        #1;
        check("t5_ready",     64'(store_ready_o), 64'(1));
        check("t5_populated", 64'(populated_o),   64'(0));
        check("t5_overflow",  64'(overflow_o),    64'(0));
        check("t5_fdata",     64'(fetch_data_o),  64'(0));
        fetch_rd_i = 1'b0;
        #1;
        check("t5_stall",     64'(fetch_stall_o), 64'(0));
        cyc();
        rstn_i = 1'b1;
        repeat (2) cyc();
        check("t5_fdata_hold", 64'(fetch_data_o), 64'(0));
        push_word(36'h777);
        repeat (3) cyc();
        check("t5_populated1", 64'(populated_o), 64'(1));
        fetch_check(3'd0, 36'h777, "t5_fetch0");

        // Random traffic; every RAM location has been written by now.
        for (int i = 0; i < 1500; i++) begin
            store_valid_i = ($urandom_range(3, 0) != 0);
            store_data_i  = {4'($urandom_range(15, 0)), 32'($urandom())};
            fetch_rd_i    = ($urandom_range(1, 0) != 0);
            fetch_addr_i  = 3'($urandom_range(7, 0));
            clear_i       = ($urandom_range(49, 0) == 0);
            cyc();
        end
        store_valid_i = 1'b0;
        fetch_rd_i    = 1'b0;
        clear_i       = 1'b0;
        repeat (4) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
